instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Front-end fetch stage that owns the program counter. The counter's output is this block's `pc` input. The block drives the counter's load controls (`pc_set`, `pc_next`) and issues byte reads to instruction memory over a req/ack handshake. It assembles 1- or 2-byte instructions and hands them to decode over a valid/ready handshake. Branch redirects from execute reload the PC and abort the fetch in progress.

Parameters:
- ADDR_WIDTH, 8, width of PC and memory address
- DATA_WIDTH, 8, width of a memory byte / opcode / operand
- RESET_VECTOR, 0, PC value loaded while reset is high
- LONG_BIT, 7, opcode bit index; when set, the instruction carries one operand byte

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pc  in  ADDR_WIDTH  current program counter value
- pc_set  out  1  load PC from pc_next this cycle; when low, PC increments by 1
- pc_next  out  ADDR_WIDTH  PC load value
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_WIDTH  read address
- mem_ack  in  1  read data valid / request accepted
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack
- branch_valid  in  1  redirect request from execute
- branch_target  in  ADDR_WIDTH  redirect address
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts instruction
- instr_opcode  out  DATA_WIDTH  opcode byte
- instr_operand  out  DATA_WIDTH  operand byte (0 for 1-byte instructions)
- instr_addr  out  ADDR_WIDTH  address of the opcode byte
- instr_long  out  1  instruction is 2 bytes

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high; all state changes on posedge clock.
- Reset:
  - state=FETCH_OP; instr_valid=0; instr_opcode/operand/addr/long=0.
  - While reset is high, pc_set=1 and pc_next=RESET_VECTOR, so the PC holds RESET_VECTOR.
  - mem_req=0 while reset is high.
- States:
  - FETCH_OP: mem_req=1, mem_addr=pc. On mem_ack:
    - latch opcode and instr_addr=pc; PC increments (pc_set=0).
    - If mem_rdata[LONG_BIT]=1, go to FETCH_ARG.
    - Otherwise operand=0, long=0, go to ISSUE.
  - FETCH_ARG: mem_req=1, mem_addr=pc. On mem_ack: latch operand, long=1, PC increments, go to ISSUE.
  - ISSUE: mem_req=0, instr_valid=1. On instr_ready: transfer, go to FETCH_OP; instr_valid=0 the next cycle.
- PC control (combinational):
  - Default is pc_set=1, pc_next=pc (hold).
  - pc_set=0 only in an accepted-ack cycle with no branch.
  - Branch cycle: pc_set=1, pc_next=branch_target.
- Memory handshake:
  - mem_req and mem_addr hold stable until mem_ack.
  - A same-cycle ack (combinational memory) is legal.
  - mem_ack while mem_req=0 is ignored.
- Branch (any state, highest priority):
  - pc loads branch_target; next state is FETCH_OP; instr_valid=0 the next cycle.
  - An ack in the branch cycle is discarded and the PC does not increment.
  - An ISSUE transfer (valid&ready) coinciding with branch_valid completes normally; decode owns that instruction.
  - An un-transferred instruction in ISSUE is dropped.
- Latency:
  - 1-byte instruction, 1-cycle ack: instr_valid 1 cycle after ack.
  - 2-byte instruction: 2 fetch cycles, then ISSUE.
  - Peak throughput is one 1-byte instruction per 2 cycles.
- Wrap-around: PC wraps modulo 2^ADDR_WIDTH; an opcode at all-ones fetches its operand from address 0.
- Stall: instr_* outputs hold stable while instr_valid=1 and instr_ready=0.
- Reset mid-operation: takes effect in the reset cycle; a pending fetch is abandoned and its late ack is ignored.

Test Plan:
- Reset, RESET_VECTOR=0x10, memory acks immediately with 0x05 -> mem_addr=0x10; instr_valid 1 cycle later with opcode=0x05, operand=0, addr=0x10, long=0; pc=0x11.
- Bytes 0x85,0x3C at 0x20/0x21 with ack delayed 2 cycles each -> mem_req held and PC held during waits; issue opcode=0x85, operand=0x3C, addr=0x20, long=1; pc=0x22.
- instr_ready low for 5 cycles in ISSUE -> outputs stable, mem_req=0, PC unchanged; transfer on ready, then fetch resumes at the next PC.
- branch_valid with target 0x40 during FETCH_ARG, ack in the same cycle -> ack discarded, no issue, next mem_addr=0x40; also branch during a stalled ISSUE -> instruction dropped, instr_valid=0 next cycle.
- Long opcode at 0xFF -> operand fetched from 0x00; pc=0x01 after issue.
- Reset asserted while FETCH_OP waits, ack arrives 1 cycle after reset deasserts -> that ack is accepted only as a fresh fetch at RESET_VECTOR; no stale data issued.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC counter controls, instruction memory read
// port, branch redirect input and the decode-side handshake.
interface instruction_fetch_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] pc;
   logic                  pc_set;
   logic [ADDR_WIDTH-1:0] pc_next;

   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic                  branch_valid;
   logic [ADDR_WIDTH-1:0] branch_target;

   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_WIDTH-1:0] instr_opcode;
   logic [DATA_WIDTH-1:0] instr_operand;
   logic [ADDR_WIDTH-1:0] instr_addr;
   logic                  instr_long;

   modport master (
      input  pc,
      output pc_set,
      output pc_next,
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata,
      input  branch_valid,
      input  branch_target,
      output instr_valid,
      input  instr_ready,
      output instr_opcode,
      output instr_operand,
      output instr_addr,
      output instr_long
   );

   modport slave (
      output pc,
      input  pc_set,
      input  pc_next,
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata,
      output branch_valid,
      output branch_target,
      input  instr_valid,
      output instr_ready,
      input  instr_opcode,
      input  instr_operand,
      input  instr_addr,
      input  instr_long
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: reads 1- or 2-byte instructions a byte at a time,
// steers the external PC counter and hands results to decode.
module instruction_fetch #(
   parameter int                    ADDR_WIDTH   = 8,
   parameter int                    DATA_WIDTH   = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                    LONG_BIT     = 7
) (
   input logic                  clock,
   input logic                  reset,
   instruction_fetch_if.master  bus
);

   typedef enum logic [1:0] {
      FETCH_OP,
      FETCH_ARG,
      ISSUE
   } state_t;

   state_t                state;
   logic                  valid;
   logic [DATA_WIDTH-1:0] opcode;
   logic [DATA_WIDTH-1:0] operand;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic                  is_long;

   logic                  fetching;
   logic                  take;

   // A read is outstanding in both fetch states; the PC is the address.
   assign fetching     = !reset && (state != ISSUE);
   assign take         = fetching && bus.mem_ack && !bus.branch_valid;
   assign bus.mem_req  = fetching;
   assign bus.mem_addr = bus.pc;

   assign bus.instr_valid   = valid;
   assign bus.instr_opcode  = opcode;
   assign bus.instr_operand = operand;
   assign bus.instr_addr    = op_addr;
   assign bus.instr_long    = is_long;

   // PC steering: reset vector, then redirect, then step on an accepted byte.
   always_comb begin
      bus.pc_set  = 1'b1;
      bus.pc_next = bus.pc;
      if (reset) begin
         bus.pc_next = RESET_VECTOR;
      end else if (bus.branch_valid) begin
         bus.pc_next = bus.branch_target;
      end else if (take) begin
         bus.pc_set = 1'b0;
      end
   end

   // Fetch sequencer; a redirect aborts any fetch and drops a pending issue.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= FETCH_OP;
         valid   <= 1'b0;
         opcode  <= '0;
         operand <= '0;
         op_addr <= '0;
         is_long <= 1'b0;
      end else if (bus.branch_valid) begin
         state <= FETCH_OP;
         valid <= 1'b0;
      end else begin
         unique case (state)
            FETCH_OP: begin
               if (bus.mem_ack) begin
                  opcode  <= bus.mem_rdata;
                  op_addr <= bus.pc;
                  if (bus.mem_rdata[LONG_BIT]) begin
                     state <= FETCH_ARG;
                  end else begin
                     operand <= '0;
                     is_long <= 1'b0;
                     valid   <= 1'b1;
                     state   <= ISSUE;
                  end
               end
            end
            FETCH_ARG: begin
               if (bus.mem_ack) begin
                  operand <= bus.mem_rdata;
                  is_long <= 1'b1;
                  valid   <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.instr_ready) begin
                  valid <= 1'b0;
                  state <= FETCH_OP;
               end
            end
            default: begin
               state <= FETCH_OP;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios, then random
// ack/ready/branch traffic against a program-walk reference model.
module tb_instruction_fetch;

   localparam int         AW = 8;
   localparam int         DW = 8;
   localparam logic [7:0] RV = 8'h10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   instruction_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   instruction_fetch #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .RESET_VECTOR(RV),
      .LONG_BIT    (7)
   ) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   logic [7:0] mem [256];
   int         ack_delay  = 0;
   int         wait_cnt   = 0;
   logic       ack_manual = 1'b0;
   logic       man_ack    = 1'b0;

   assign bus.mem_ack = ack_manual ? man_ack
                      : (bus.mem_req && (wait_cnt >= ack_delay));
   assign bus.mem_rdata = mem[bus.mem_addr];

   // Memory wait counter and the external PC counter.
   always @(posedge clk) begin
      if (!bus.mem_req || bus.mem_ack || bus.branch_valid)
         wait_cnt <= 0;
      else
         wait_cnt <= wait_cnt + 1;
      bus.pc <= bus.pc_set ? bus.pc_next : bus.pc + 8'd1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] model_pc;
   logic [7:0] e_op;
   logic [7:0] e_arg;
   logic [7:0] a1;
   logic       e_long;
   logic       br;
   logic       hold_v;
   logic [7:0] h_op;
   logic [7:0] h_arg;
   logic [7:0] h_addr;
   logic       h_long;
   int         n_xfer;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h05;
      mem[8'h20] = 8'h85;
      mem[8'h21] = 8'h3C;
      mem[8'h22] = 8'h90;
      mem[8'h23] = 8'h11;
      mem[8'h40] = 8'h07;
      mem[8'hFF] = 8'h81;
      mem[8'h00] = 8'h22;
      bus.branch_valid  = 1'b0;
      bus.branch_target = 8'h00;
      bus.instr_ready   = 1'b0;
      ack_delay = 0;

      // Reset state
      rst = 1'b1;
      step();
      step();
      chk1("rst_req", bus.mem_req, 1'b0);
      chk1("rst_pc_set", bus.pc_set, 1'b1);
      chk8("rst_pc_next", bus.pc_next, RV);
      chk1("rst_valid", bus.instr_valid, 1'b0);
      chk8("rst_opcode", bus.instr_opcode, 8'h00);
      chk8("rst_pc", bus.pc, RV);

      // Short instruction, immediate ack
      rst = 1'b0;
      #1;
      chk1("t1_req", bus.mem_req, 1'b1);
      chk8("t1_addr", bus.mem_addr, 8'h10);
      chk1("t1_pc_set", bus.pc_set, 1'b0);
      step();
      chk1("t1_valid", bus.instr_valid, 1'b1);
      chk8("t1_opcode", bus.instr_opcode, 8'h05);
      chk8("t1_operand", bus.instr_operand, 8'h00);
      chk8("t1_iaddr", bus.instr_addr, 8'h10);
      chk1("t1_long", bus.instr_long, 1'b0);
      chk8("t1_pc", bus.pc, 8'h11);

      // Decode stall for 5 cycles
      for (int i = 0; i < 5; i++) begin
         chk1("st_valid", bus.instr_valid, 1'b1);
         chk8("st_opcode", bus.instr_opcode, 8'h05);
         chk8("st_iaddr", bus.instr_addr, 8'h10);
         chk1("st_req", bus.mem_req, 1'b0);
         chk8("st_pc", bus.pc, 8'h11);
         step();
      end
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
      #1;
      chk1("st_after_valid", bus.instr_valid, 1'b0);
      chk1("st_after_req", bus.mem_req, 1'b1);
      chk8("st_after_addr", bus.mem_addr, 8'h11);

      // Redirect to 0x20 while an ack lands: ack discarded
      bus.branch_valid  = 1'b1;
      bus.branch_target = 8'h20;
      #1;
      chk1("br1_ack", bus.mem_ack, 1'b1);
      chk1("br1_pc_set", bus.pc_set, 1'b1);
      chk8("br1_pc_next", bus.pc_next, 8'h20);
      ack_delay = 2;
      step();
      bus.branch_valid = 1'b0;
      #1;
      chk1("br1_valid", bus.instr_valid, 1'b0);

      // Long instruction with 2-cycle ack latency per byte
      for (int i = 0; i < 2; i++) begin
         chk1("w_op_req", bus.mem_req, 1'b1);
         chk8("w_op_addr", bus.mem_addr, 8'h20);
         chk1("w_op_pc_set", bus.pc_set, 1'b1);
         chk8("w_op_pc_next", bus.pc_next, 8'h20);
         step();
      end
      chk1("w_op_ack", bus.mem_ack, 1'b1);
      chk1("w_op_inc", bus.pc_set, 1'b0);
      step();
      for (int i = 0; i < 2; i++) begin
         chk1("w_arg_req", bus.mem_req, 1'b1);
         chk8("w_arg_addr", bus.mem_addr, 8'h21);
         chk8("w_arg_pc", bus.pc, 8'h21);
         chk1("w_arg_valid", bus.instr_valid, 1'b0);
         step();
      end
      chk1("w_arg_ack", bus.mem_ack, 1'b1);
      step();
      chk1("t2_valid", bus.instr_valid, 1'b1);
      chk8("t2_opcode", bus.instr_opcode, 8'h85);
      chk8("t2_operand", bus.instr_operand, 8'h3C);
      chk8("t2_iaddr", bus.instr_addr, 8'h20);
      chk1("t2_long", bus.instr_long, 1'b1);
      chk8("t2_pc", bus.pc, 8'h22);
      chk1("t2_req", bus.mem_req, 1'b0);
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
      ack_delay = 0;
      #1;

      // Redirect during FETCH_ARG with a same-cycle ack
      chk8("t4_addr", bus.mem_addr, 8'h22);
      step();
      chk8("t4_arg_addr", bus.mem_addr, 8'h23);
      bus.branch_valid  = 1'b1;
      bus.branch_target = 8'h40;
      #1;
      chk1("t4_ack", bus.mem_ack, 1'b1);
      chk1("t4_pc_set", bus.pc_set, 1'b1);
      chk8("t4_pc_next", bus.pc_next, 8'h40);
      step();
      bus.branch_valid = 1'b0;
      #1;
      chk1("t4_valid", bus.instr_valid, 1'b0);
      chk1("t4_req", bus.mem_req, 1'b1);
      chk8("t4_new_addr", bus.mem_addr, 8'h40);
      chk8("t4_pc", bus.pc, 8'h40);
      step();
      chk1("t4b_valid", bus.instr_valid, 1'b1);
      chk8("t4b_opcode", bus.instr_opcode, 8'h07);
      chk8("t4b_iaddr", bus.instr_addr, 8'h40);
      chk8("t4b_operand", bus.instr_operand, 8'h00);
      chk1("t4b_long", bus.instr_long, 1'b0);

      // Ack without a request is ignored
      ack_manual = 1'b1;
      man_ack    = 1'b1;
      #1;
      chk1("idle_ack_pc_set", bus.pc_set, 1'b1);
      step();
      chk8("idle_ack_pc", bus.pc, 8'h41);
      chk1("idle_ack_valid", bus.instr_valid, 1'b1);
      chk8("idle_ack_opcode", bus.instr_opcode, 8'h07);
      ack_manual = 1'b0;
      man_ack    = 1'b0;

      // Redirect during a stalled ISSUE drops the instruction
      bus.branch_valid  = 1'b1;
      bus.branch_target = 8'h50;
      #1;
      chk8("t4c_pc_next", bus.pc_next, 8'h50);
      step();
      bus.branch_valid = 1'b0;
      #1;
      chk1("t4c_valid", bus.instr_valid, 1'b0);
      chk8("t4c_addr", bus.mem_addr, 8'h50);

      // Long opcode at 0xFF wraps to 0x00 for its operand
      bus.branch_valid  = 1'b1;
      bus.branch_target = 8'hFF;
      step();
      bus.branch_valid = 1'b0;
      #1;
      chk8("t5_addr", bus.mem_addr, 8'hFF);
      step();
      chk8("t5_arg_addr", bus.mem_addr, 8'h00);
      step();
      chk1("t5_valid", bus.instr_valid, 1'b1);
      chk8("t5_opcode", bus.instr_opcode, 8'h81);
      chk8("t5_operand", bus.instr_operand, 8'h22);
      chk8("t5_iaddr", bus.instr_addr, 8'hFF);
      chk1("t5_long", bus.instr_long, 1'b1);
      chk8("t5_pc", bus.pc, 8'h01);
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;

      // Reset while a fetch waits; the late ack is a fresh fetch
      ack_manual = 1'b1;
      man_ack    = 1'b0;
      #1;
      chk1("t6_req", bus.mem_req, 1'b1);
      chk8("t6_addr", bus.mem_addr, 8'h01);
      step();
      rst = 1'b1;
      #1;
      chk1("t6_rst_req", bus.mem_req, 1'b0);
      chk1("t6_rst_pc_set", bus.pc_set, 1'b1);
      chk8("t6_rst_pc_next", bus.pc_next, RV);
      step();
      rst     = 1'b0;
      man_ack = 1'b1;
      #1;
      chk8("t6_addr2", bus.mem_addr, RV);
      chk1("t6_valid0", bus.instr_valid, 1'b0);
      step();
      man_ack    = 1'b0;
      ack_manual = 1'b0;
      #1;
      chk1("t6_valid", bus.instr_valid, 1'b1);
      chk8("t6_opcode", bus.instr_opcode, 8'h05);
      chk8("t6_iaddr", bus.instr_addr, RV);
      chk8("t6_pc", bus.pc, 8'h11);

      // Random traffic against a program-walk model
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      bus.instr_ready  = 1'b0;
      bus.branch_valid = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst      = 1'b0;
      model_pc = RV;
      hold_v   = 1'b0;
      n_xfer   = 0;
      h_op     = 8'h00;
      h_arg    = 8'h00;
      h_addr   = 8'h00;
      h_long   = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         ack_delay         = int'($urandom_range(0, 2));
         bus.instr_ready   = ($urandom_range(0, 2) != 0);
         br                = ($urandom_range(0, 19) == 0);
         bus.branch_valid  = br;
         bus.branch_target = 8'($urandom);
         #1;
         if (hold_v) begin
            chk1("rnd_hold_valid", bus.instr_valid, 1'b1);
            chk8("rnd_hold_op", bus.instr_opcode, h_op);
            chk8("rnd_hold_arg", bus.instr_operand, h_arg);
            chk8("rnd_hold_addr", bus.instr_addr, h_addr);
            chk1("rnd_hold_long", bus.instr_long, h_long);
         end
         if (bus.instr_valid)
            chk1("rnd_req_idle", bus.mem_req, 1'b0);
         if (bus.instr_valid && bus.instr_ready) begin
            a1     = model_pc + 8'd1;
            e_op   = mem[model_pc];
            e_long = e_op[7];
            e_arg  = e_long ? mem[a1] : 8'h00;
            chk8("rnd_opcode", bus.instr_opcode, e_op);
            chk8("rnd_operand", bus.instr_operand, e_arg);
            chk8("rnd_iaddr", bus.instr_addr, model_pc);
            chk1("rnd_long", bus.instr_long, e_long);
            model_pc = e_long ? model_pc + 8'd2 : a1;
            n_xfer++;
         end
         hold_v = bus.instr_valid && !bus.instr_ready && !br;
         h_op   = bus.instr_opcode;
         h_arg  = bus.instr_operand;
         h_addr = bus.instr_addr;
         h_long = bus.instr_long;
         if (br) model_pc = bus.branch_target;
         step();
      end
      bus.branch_valid = 1'b0;
      chk1("rnd_xfers", n_xfer >= 100, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
